// File: rtl/comb_job_scheduler_if.sv
// Client-side request/response bus of comb_job_scheduler: requesters drive
// operands and response accepts, the scheduler drives accepts and responses.
interface comb_job_scheduler_if #(
  parameter int NREQ = 4,
  parameter int NW   = 8,
  parameter int RW   = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ*NW-1:0] req_m;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_n, req_m, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_n, req_m, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/comb_job_scheduler.sv
// Round-robin scheduler sharing one C(n,m) engine among NREQ requesters.
// Optional WAIT-state watchdog is enabled by defining COMB_SCHED_WATCHDOG_EN.
module comb_job_scheduler #(
  parameter int NREQ        = 4,
  parameter int NW          = 8,
  parameter int RW          = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  comb_job_scheduler_if.slave     bus,
  output logic                    eng_start,
  output logic [NW-1:0]           eng_n,
  output logic [NW-1:0]           eng_m,
  output logic                    eng_abort,
  input  logic                    eng_done,
  input  logic [RW-1:0]           eng_result,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            eng_start_q, eng_start_d;
  logic [NW-1:0]   eng_n_q, eng_n_d;
  logic [NW-1:0]   eng_m_q, eng_m_d;
  logic            busy_q, busy_d;
  logic            found;
  logic [IDW-1:0]  winner;

`ifdef COMB_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0]   wdog_q, wdog_d;
  logic            eng_abort_q, eng_abort_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  // First valid requester at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      automatic int idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    eng_start_d = 1'b0;
    eng_n_d     = eng_n_q;
    eng_m_d     = eng_m_q;
`ifdef COMB_SCHED_WATCHDOG_EN
    wdog_d      = wdog_q;
    eng_abort_d = 1'b0;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d             = S_GRANT;
          grant_id_d          = winner;
          req_ready_d[winner] = 1'b1;
          eng_n_d             = bus.req_n[int'(winner)*NW +: NW];
          eng_m_d             = bus.req_m[int'(winner)*NW +: NW];
        end
      end
      S_GRANT: begin
        if (eng_m_q > eng_n_q) begin
          // C(n,m)=0 for m>n: answer directly without occupying the engine.
          state_d                 = S_RESP;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          rsp_data_d              = '0;
`ifdef COMB_SCHED_WATCHDOG_EN
          rsp_err_d               = 1'b0;
`endif
        end else begin
          state_d     = S_LAUNCH;
          eng_start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef COMB_SCHED_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d                 = S_RESP;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          rsp_data_d              = eng_result;
`ifdef COMB_SCHED_WATCHDOG_EN
          rsp_err_d               = 1'b0;
        end else if (wdog_q == CW'(WDOG_CYCLES - 1)) begin
          state_d                 = S_RESP;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          rsp_data_d              = '0;
          rsp_err_d               = 1'b1;
          eng_abort_d             = 1'b1;
        end else begin
          wdog_d                  = wdog_q + CW'(1);
`endif
        end
      end
      S_RESP: begin
        if (bus.rsp_ready[grant_id_q]) begin
          state_d     = S_IDLE;
          rsp_valid_d = '0;
          rr_ptr_d    = (int'(grant_id_q) == NREQ - 1) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      eng_start_q <= 1'b0;
      eng_n_q     <= '0;
      eng_m_q     <= '0;
      busy_q      <= 1'b0;
`ifdef COMB_SCHED_WATCHDOG_EN
      wdog_q      <= '0;
      eng_abort_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      eng_start_q <= eng_start_d;
      eng_n_q     <= eng_n_d;
      eng_m_q     <= eng_m_d;
      busy_q      <= busy_d;
`ifdef COMB_SCHED_WATCHDOG_EN
      wdog_q      <= wdog_d;
      eng_abort_q <= eng_abort_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign eng_start     = eng_start_q;
  assign eng_n         = eng_n_q;
  assign eng_m         = eng_m_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;
`ifdef COMB_SCHED_WATCHDOG_EN
  assign eng_abort     = eng_abort_q;
  assign bus.rsp_err   = rsp_err_q;
`else
  assign eng_abort     = 1'b0;
  assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_comb_job_scheduler.sv
// Directed bench for comb_job_scheduler: expected responses go into a scoreboard
// queue that a separate monitor compares against every presented response.
module tb_comb_job_scheduler;
  localparam int NREQ = 4;
  localparam int NW   = 8;
  localparam int RW   = 16;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          eng_start;
  logic [NW-1:0] eng_n;
  logic [NW-1:0] eng_m;
  logic          eng_abort;
  logic          eng_done;
  logic [RW-1:0] eng_result;
  logic          busy;
  logic [1:0]    grant_id;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_starts = 0;
  exp_t exp_q[$];

  comb_job_scheduler_if #(.NREQ(NREQ), .NW(NW), .RW(RW)) bus ();

  comb_job_scheduler #(.NREQ(NREQ), .NW(NW), .RW(RW), .WDOG_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .eng_start  (eng_start),
    .eng_n      (eng_n),
    .eng_m      (eng_m),
    .eng_abort  (eng_abort),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: compares every presented response, pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e = exp_q[0];
          check("rsp_valid_onehot", 64'(bus.rsp_valid), 64'(4'b0001 << e.id));
          check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          if ((bus.rsp_valid & bus.rsp_ready) != '0) e = exp_q.pop_front();
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (eng_start) n_starts++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int n, input int m);
    bus.req_n[id*NW +: NW] = NW'(n);
    bus.req_m[id*NW +: NW] = NW'(m);
    bus.req_valid[id]      = 1'b1;
  endtask

  task automatic wait_req_ready(input int id);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.req_ready != '0) break;
    end
    check("req_ready_onehot", 64'(bus.req_ready), 64'(4'b0001 << id));
    check("grant_id", 64'(grant_id), 64'(id));
  endtask

  task automatic wait_eng_start(input int n, input int m);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eng_start) break;
    end
    check("eng_start_seen", 64'(eng_start), 64'd1);
    check("eng_n", 64'(eng_n), 64'(n));
    check("eng_m", 64'(eng_m), 64'(m));
  endtask

  task automatic finish_engine(input int delay, input int value);
    repeat (delay) tick();
    eng_done   = 1'b1;
    eng_result = RW'(value);
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
    check("rsp_after_done", 64'(bus.rsp_valid != '0), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int start_snap;
    int k;
    int n_tab[4] = '{4, 6, 7, 8};
    int m_tab[4] = '{2, 3, 0, 4};
    int r_tab[4] = '{6, 20, 1, 70};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_n     = '0;
    bus.req_m     = '0;
    bus.rsp_ready = '1;
    eng_done      = 1'b0;
    eng_result    = '0;
    do_reset();

    // Reset state
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_eng_start", 64'(eng_start), 64'd0);

    // 1: C(5,2)=10 on requester 1, exact launch and response latency
    exp_q.push_back('{1, 16'd10, 1'b0});
    set_req(1, 5, 2);
    tick();
    check("t1_req_ready", 64'(bus.req_ready), 64'b0010);
    check("t1_busy", 64'(busy), 64'd1);
    bus.req_valid = '0;
    tick();
    check("t1_eng_start", 64'(eng_start), 64'd1);
    check("t1_eng_n", 64'(eng_n), 64'd5);
    check("t1_eng_m", 64'(eng_m), 64'd2);
    check("t1_req_ready_pulse", 64'(bus.req_ready), 64'd0);
    tick();
    check("t1_eng_start_pulse", 64'(eng_start), 64'd0);
    finish_engine(28, 10);
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'b0010);
    drain();

    // 2: all requesters valid after reset -> grants 0,1,2,3,0
    do_reset();
    for (int id = 0; id < NREQ; id++) set_req(id, n_tab[id], m_tab[id]);
    for (int j = 0; j < 5; j++) begin
      k = j % NREQ;
      exp_q.push_back('{k, 16'(r_tab[k]), 1'b0});
      wait_req_ready(k);
      if (j == 4) bus.req_valid = '0;
      wait_eng_start(n_tab[k], m_tab[k]);
      finish_engine(3, r_tab[k]);
    end
    drain();

    // 3: m>n answered directly, two cycles after the request
    start_snap = n_starts;
    exp_q.push_back('{2, 16'd0, 1'b0});
    set_req(2, 3, 5);
    tick();
    check("t3_req_ready", 64'(bus.req_ready), 64'b0100);
    bus.req_valid = '0;
    tick();
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    check("t3_eng_start", 64'(eng_start), 64'd0);
    drain();
    check("t3_no_launch", 64'(n_starts), 64'(start_snap));

    // 4: response backpressure holds everything; waiting requester served after release
    bus.rsp_ready = '0;
    exp_q.push_back('{0, 16'd1, 1'b0});
    set_req(0, 5, 5);
    wait_req_ready(0);
    bus.req_valid = '0;
    set_req(3, 3, 1);
    wait_eng_start(5, 5);
    finish_engine(2, 1);
    start_snap = n_starts;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_rsp_held", 64'(bus.rsp_valid), 64'b0001);
      check("t4_no_req_ready", 64'(bus.req_ready), 64'd0);
    end
    check("t4_no_launch", 64'(n_starts), 64'(start_snap));
    exp_q.push_back('{3, 16'd3, 1'b0});
    bus.rsp_ready = '1;
    wait_req_ready(3);
    bus.req_valid = '0;
    wait_eng_start(3, 1);
    finish_engine(4, 3);
    drain();

    // 5: reset during WAIT abandons the job and restarts arbitration at 0
    exp_q.push_back('{2, 16'd0, 1'b0});
    set_req(2, 1, 4);
    wait_req_ready(2);
    bus.req_valid = '0;
    drain();
    set_req(3, 4, 1);
    wait_req_ready(3);
    bus.req_valid = '0;
    wait_eng_start(4, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_req_ready", 64'(bus.req_ready), 64'd0);
    check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t5_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("t5_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("t5_eng_start", 64'(eng_start), 64'd0);
    check("t5_eng_n", 64'(eng_n), 64'd0);
    check("t5_eng_m", 64'(eng_m), 64'd0);
    check("t5_eng_abort", 64'(eng_abort), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_grant_id", 64'(grant_id), 64'd0);
    tick();
    eng_done   = 1'b1;
    eng_result = RW'(4);
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
    repeat (3) tick();
    check("t5_done_ignored_busy", 64'(busy), 64'd0);
    check("t5_done_ignored_rsp", 64'(bus.rsp_valid), 64'd0);
    exp_q.push_back('{0, 16'd0, 1'b0});
    set_req(3, 6, 1);
    set_req(0, 2, 3);
    wait_req_ready(0);
    bus.req_valid = '0;
    drain();

`ifdef COMB_SCHED_WATCHDOG_EN
    // 6: engine never completes -> abort after 64 WAIT cycles
    exp_q.push_back('{1, 16'd0, 1'b1});
    set_req(1, 6, 2);
    wait_req_ready(1);
    bus.req_valid = '0;
    wait_eng_start(6, 2);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (eng_abort) begin
        k = i;
        break;
      end
    end
    check("t6_abort_cycle", 64'(k), 64'd65);
    tick();
    check("t6_abort_pulse", 64'(eng_abort), 64'd0);
    drain();
`endif

    repeat (5) tick();
    check("final_idle", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
